// File: rtl/jzjpcc_decode_stage.sv
// jzjpcc_decode_stage
// Decode half of the decode-to-execute link: slices register-file read
// addresses from the fetched RV32I word, decodes immediate and ALU control
// for OP / OP-IMM / LUI / AUIPC, and owns the pipeline register that feeds
// the execute stage (stall hold, flush bubble, unsupported-opcode bubble).
module jzjpcc_decode_stage #(
    parameter int PC_MAX_B = 31
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         instruction,
    input  logic [PC_MAX_B:2]   instructionPC,
    input  logic                instructionValid,
    input  logic                stall,
    input  logic                flush,
    output logic [4:0]          rs1Addr,
    output logic [4:0]          rs2Addr,
    input  logic [31:0]         rs1Data,
    input  logic [31:0]         rs2Data,
    output logic [31:0]         immediate,
    output logic [31:0]         rs1,
    output logic [31:0]         rs2,
    output logic [PC_MAX_B:2]   currentPC,
    output logic [4:0]          rdAddr,
    output logic [2:0]          aluOperation,
    output logic                aluMod,
    output logic [1:0]          aluMuxMode,
    output logic                rdWriteEnable,
    output logic                unsupportedInstruction
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [1:0] {
        MUX_RS1_RS2 = 2'b00,
        MUX_RS1_IMM = 2'b01,
        MUX_PC_IMM  = 2'b10,
        MUX_ZERO_IMM = 2'b11
    } aluMux_e;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rdField;

    assign opcode  = instruction[6:0];
    assign funct3  = instruction[14:12];
    assign rdField = instruction[11:7];

    // Register-file read addresses are raw slices, independent of valid/stall/flush
    assign rs1Addr = instruction[19:15];
    assign rs2Addr = instruction[24:20];

    // Decoded (pre-register) control
    logic [31:0] decImmediate;
    logic [2:0]  decAluOperation;
    logic        decAluMod;
    logic [1:0]  decAluMuxMode;
    logic        decSupported;
    logic        decWriteEnable;

    // Next-state of the execute bundle
    logic [31:0]       nxtImmediate;
    logic [31:0]       nxtRs1;
    logic [31:0]       nxtRs2;
    logic [PC_MAX_B:2] nxtCurrentPC;
    logic [4:0]        nxtRdAddr;
    logic [2:0]        nxtAluOperation;
    logic              nxtAluMod;
    logic [1:0]        nxtAluMuxMode;
    logic              nxtRdWriteEnable;
    logic              nxtUnsupported;

    // Opcode decode: immediate format, ALU operation/modifier and operand muxing
    always_comb begin
        decImmediate    = '0;
        decAluOperation = '0;
        decAluMod       = 1'b0;
        decAluMuxMode   = MUX_RS1_RS2;
        decSupported    = 1'b0;

        case (opcode)
            OPC_OP: begin
                decSupported    = 1'b1;
                decAluMuxMode   = MUX_RS1_RS2;
                decAluOperation = funct3;
                // Only ADD/SUB and SRL/SRA use bit 30 as an operation modifier
                if ((funct3 == 3'b000) || (funct3 == 3'b101)) begin
                    decAluMod = instruction[30];
                end
            end
            OPC_OP_IMM: begin
                decSupported    = 1'b1;
                decAluMuxMode   = MUX_RS1_IMM;
                decAluOperation = funct3;
                // Shifts take a 5-bit shamt; bit 30 is then the SRAI selector, not immediate data
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    decImmediate = {27'b0, instruction[24:20]};
                end else begin
                    decImmediate = {{20{instruction[31]}}, instruction[31:20]};
                end
                if (funct3 == 3'b101) begin
                    decAluMod = instruction[30];
                end
            end
            OPC_LUI: begin
                decSupported  = 1'b1;
                decAluMuxMode = MUX_ZERO_IMM;
                decImmediate  = {instruction[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                decSupported  = 1'b1;
                decAluMuxMode = MUX_PC_IMM;
                decImmediate  = {instruction[31:12], 12'b0};
            end
            default: begin
                decSupported = 1'b0;
            end
        endcase

        decWriteEnable = decSupported && (rdField != 5'd0);
    end

    // Select the next execute bundle: flush > stall > invalid > decode
    always_comb begin
        nxtImmediate     = '0;
        nxtRs1           = '0;
        nxtRs2           = '0;
        nxtCurrentPC     = '0;
        nxtRdAddr        = '0;
        nxtAluOperation  = '0;
        nxtAluMod        = 1'b0;
        nxtAluMuxMode    = '0;
        nxtRdWriteEnable = 1'b0;
        nxtUnsupported   = 1'b0;

        if (flush) begin
            // bubble: defaults above
        end else if (stall) begin
            // Hold the bundle; the unsupported flag is a one-cycle pulse and drops
            nxtImmediate     = immediate;
            nxtRs1           = rs1;
            nxtRs2           = rs2;
            nxtCurrentPC     = currentPC;
            nxtRdAddr        = rdAddr;
            nxtAluOperation  = aluOperation;
            nxtAluMod        = aluMod;
            nxtAluMuxMode    = aluMuxMode;
            nxtRdWriteEnable = rdWriteEnable;
        end else if (!instructionValid) begin
            // bubble: defaults above
        end else if (!decSupported) begin
            nxtUnsupported = 1'b1;
        end else begin
            nxtImmediate     = decImmediate;
            nxtRs1           = rs1Data;
            nxtRs2           = rs2Data;
            nxtCurrentPC     = instructionPC;
            nxtRdAddr        = rdField;
            nxtAluOperation  = decAluOperation;
            nxtAluMod        = decAluMod;
            nxtAluMuxMode    = decAluMuxMode;
            nxtRdWriteEnable = decWriteEnable;
        end
    end

    // Decode/execute pipeline register; asynchronous reset leaves a bubble
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            immediate              <= '0;
            rs1                    <= '0;
            rs2                    <= '0;
            currentPC              <= '0;
            rdAddr                 <= '0;
            aluOperation           <= '0;
            aluMod                 <= 1'b0;
            aluMuxMode             <= '0;
            rdWriteEnable          <= 1'b0;
            unsupportedInstruction <= 1'b0;
        end else begin
            immediate              <= nxtImmediate;
            rs1                    <= nxtRs1;
            rs2                    <= nxtRs2;
            currentPC              <= nxtCurrentPC;
            rdAddr                 <= nxtRdAddr;
            aluOperation           <= nxtAluOperation;
            aluMod                 <= nxtAluMod;
            aluMuxMode             <= nxtAluMuxMode;
            rdWriteEnable          <= nxtRdWriteEnable;
            unsupportedInstruction <= nxtUnsupported;
        end
    end

endmodule

// File: doc/jzjpcc_decode_stage.md
Name: jzjpcc_decode_stage

Overview:
- Producing end of the decode-to-execute pipeline link.
- Takes a fetched RV32I instruction plus its PC, drives the register-file read addresses and accepts the read data.
- Decodes immediate and ALU control, and registers all of it into the execute-stage input bundle (immediate, rs1, rs2, currentPC, rdAddr, aluOperation, aluMod, aluMuxMode, rdWriteEnable).
- Owns the pipeline register between decode and execute, including stall hold, flush bubble and unsupported-opcode bubbling.

Parameters:
PC_MAX_B, 31, MSB index of the word-aligned PC; PC ports are [PC_MAX_B:2].

Ports:
clock  input  1  single system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
instruction  input  32  fetched instruction word
instructionPC  input  [PC_MAX_B:2]  PC of instruction
instructionValid  input  1  instruction/instructionPC meaningful this cycle
stall  input  1  hold the execute bundle unchanged
flush  input  1  replace the execute bundle with a bubble
rs1Addr  output  5  instruction[19:15], combinational
rs2Addr  output  5  instruction[24:20], combinational
rs1Data  input  32  register file read data for rs1Addr, same cycle
rs2Data  input  32  register file read data for rs2Addr, same cycle
immediate  output  32  registered decoded immediate
rs1  output  32  registered rs1Data
rs2  output  32  registered rs2Data
currentPC  output  [PC_MAX_B:2]  registered instructionPC
rdAddr  output  5  registered instruction[11:7]
aluOperation  output  3  registered funct3
aluMod  output  1  registered SUB/SRA modifier
aluMuxMode  output  2  00 rs1∘rs2, 01 rs1∘imm, 10 PC∘imm, 11 0+imm
rdWriteEnable  output  1  registered writeback enable
unsupportedInstruction  output  1  registered one-cycle flag for a dropped opcode

Behaviour:
- Reset: while reset is low, every registered output is 0, asynchronously. This state is a bubble.
- Latency: one cycle. A valid instruction sampled at edge N appears on the outputs after edge N until the next update.
- Per-edge priority: flush > stall > !instructionValid > decode.
  - flush=1: load bubble.
  - flush=0 and stall=1: hold all registered outputs, except unsupportedInstruction, which is cleared.
  - instructionValid=0: load bubble.
- Bubble definition: every registered output = 0, including unsupportedInstruction.
- Decode by opcode = instruction[6:0]:
  - 0110011 (OP): aluMuxMode=00, immediate=0.
    - aluMod=instruction[30] when funct3 ∈ {000,101}, else 0.
  - 0010011 (OP-IMM): aluMuxMode=01.
    - funct3 ∈ {001,101}: immediate={27'b0,instruction[24:20]}.
    - Otherwise: immediate=sign-extended instruction[31:20].
    - aluMod=instruction[30] only for funct3=101, else 0.
  - 0110111 (LUI): aluMuxMode=11, immediate={instruction[31:12],12'b0}, aluOperation=000, aluMod=0.
  - 0010111 (AUIPC): aluMuxMode=10, same immediate as LUI, aluOperation=000, aluMod=0.
  - Any other opcode: load bubble and set unsupportedInstruction=1 for one cycle.
- For OP and OP-IMM: aluOperation=instruction[14:12].
- For all four supported opcodes: rs1=rs1Data, rs2=rs2Data, currentPC=instructionPC, rdAddr=instruction[11:7].
- rdWriteEnable=1 for supported opcodes unless rdAddr=0, in which case rdWriteEnable=0.
- rs1Addr/rs2Addr are pure slices of instruction. They are driven regardless of valid, stall or flush.
- No other state is kept: no hazard detection and no forwarding. Upstream guarantees rs1Data/rs2Data are current.

Test Plan:
- ADDI x1,x0,5 (0x00500093), valid, one edge -> immediate=0x00000005, aluMuxMode=01, aluOperation=000, aluMod=0, rdAddr=1, rdWriteEnable=1. ADDI x2,x0,-1 (0xFFF00113) -> immediate=0xFFFFFFFF.
- SUB x3,x1,x2 (0x402081B3), rs1Data=10, rs2Data=3 -> rs1Addr=1, rs2Addr=2 combinationally; after edge: rs1=10, rs2=3, aluMod=1, aluMuxMode=00, immediate=0, rdAddr=3.
- LUI x5,0x12345 (0x123452B7) -> immediate=0x12345000, aluMuxMode=11. SRAI x4,x4,3 (0x40325213) -> immediate=3, aluOperation=101, aluMod=1. ADDI x0,x0,0 -> rdWriteEnable=0.
- Load ADDI x1, then stall=1 for 3 edges while the instruction changes -> outputs unchanged. Then flush=1 with stall=1 -> all outputs 0 next edge.
- LW x1,0(x1) (0x0000A083) -> bubble, unsupportedInstruction=1 for exactly one cycle; instructionValid=0 next edge -> flag returns to 0.
- Drive reset low mid-stream, asynchronously between edges -> all outputs 0 immediately. Release -> the next valid instruction decodes normally after one edge.
